peripheral_bfm_slave_wb: RTL and testbench

Synthesizable Wishbone B3 slave front-end: accepts classic and registered-feedback burst cycles and turns each beat into a command for a backend (memory model, register file). The backend responds with ack/error and read data, which the block returns on the bus. It sits between a Wishbone master/interconnect and a storage backend and owns all bus protocol and burst address sequencing.

---
 rtl/peripheral_bfm_slave_wb.sv | 149 ++++++++++++++
 tb/tb_peripheral_bfm_slave_wb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bfm_slave_wb.sv
// Wishbone B3 slave front-end: turns classic and burst bus cycles into single-beat
// backend commands and returns the backend's ack/err and read data to the master.
module peripheral_bfm_slave_wb #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEBUG = 0
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic [1:0]      wb_bte_i,
    input  logic [2:0]      wb_cti_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o,
    output logic            cmd_valid,
    output logic            cmd_we,
    output logic [AW-1:0]   cmd_adr,
    output logic [DW-1:0]   cmd_dat,
    output logic [DW/8-1:0] cmd_sel,
    output logic            cmd_burst,
    output logic            cmd_last,
    input  logic            rsp_valid,
    input  logic            rsp_err,
    input  logic [DW-1:0]   rsp_dat
);
    localparam int SW = DW / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_adr;
    logic          r_we;
    logic [DW-1:0] r_dat;
    logic [SW-1:0] r_sel;
    logic [2:0]    r_cti;
    logic [1:0]    r_bte;
    logic          r_burst;
    logic          r_last;
    logic          r_ack;
    logic          r_err;
    logic [DW-1:0] r_datO;

    logic          w_ctiBurst;
    logic [AW-1:0] w_incAdr;
    logic [AW-1:0] w_wrapMask;
    logic [AW-1:0] w_nextAdr;
    logic [AW-1:0] w_beatAdr;

    // Beat-tracing hook for simulation builds; it carries no hardware.
    if (DEBUG != 0) begin : g_debugTrace
    end

    assign w_ctiBurst = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);
    assign w_incAdr   = r_adr + AW'(SW);

    // An all-ones mask makes the wrap merge degenerate into a plain linear increment.
    always_comb begin
        w_wrapMask = '1;
        case (r_bte)
            2'b01:   w_wrapMask = AW'(4 * SW - 1);
            2'b10:   w_wrapMask = AW'(8 * SW - 1);
            2'b11:   w_wrapMask = AW'(16 * SW - 1);
            default: w_wrapMask = '1;
        endcase
    end

    assign w_nextAdr = (r_cti == 3'b001) ? r_adr
                                         : ((r_adr & ~w_wrapMask) | (w_incAdr & w_wrapMask));
    assign w_beatAdr = (r_state == S_WAIT) ? w_nextAdr : wb_adr_i;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_cti   <= '0;
            r_bte   <= '0;
            r_burst <= 1'b0;
            r_last  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_datO  <= '0;
        end else begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_datO <= '0;
            if (!wb_cyc_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_WAIT: begin
                        if (wb_stb_i) begin
                            r_adr   <= w_beatAdr;
                            r_we    <= wb_we_i;
                            r_dat   <= wb_dat_i;
                            r_sel   <= wb_sel_i;
                            r_cti   <= wb_cti_i;
                            r_last  <= !w_ctiBurst;
                            r_burst <= w_ctiBurst || (r_state == S_WAIT);
                            if (r_state == S_IDLE) begin
                                r_bte <= wb_bte_i;
                            end
                            r_state <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (rsp_valid) begin
                            r_ack   <= !rsp_err;
                            r_err   <= rsp_err;
                            r_datO  <= (!r_we && !rsp_err) ? rsp_dat : '0;
                            r_state <= S_ACK;
                        end
                    end
                    // The master only presents the next beat after seeing ack, so
                    // a continuing burst is resampled from the sub-idle state.
                    S_ACK: begin
                        r_state <= r_last ? S_IDLE : S_WAIT;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign wb_dat_o  = r_datO;
    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_rty_o  = 1'b0;
    assign cmd_valid = (r_state == S_REQ) && wb_cyc_i;
    assign cmd_we    = r_we;
    assign cmd_adr   = r_adr;
    assign cmd_dat   = r_dat;
    assign cmd_sel   = r_sel;
    assign cmd_burst = r_burst;
    assign cmd_last  = r_last;

endmodule

// File: tb/tb_peripheral_bfm_slave_wb.sv
// Bench for peripheral_bfm_slave_wb: acts as both bus master and backend, predicting
// addresses, latency and read data from a byte-addressed memory model.
module tb_peripheral_bfm_slave_wb;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          wb_clk = 1'b0;
    logic          wb_rst;
    logic [31:0]   wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic [1:0]    wb_bte_i;
    logic [2:0]    wb_cti_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic          cmd_valid;
    logic          cmd_we;
    logic [31:0]   cmd_adr;
    logic [31:0]   cmd_dat;
    logic [3:0]    cmd_sel;
    logic          cmd_burst;
    logic          cmd_last;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_dat;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mem [logic [31:0]];

    peripheral_bfm_slave_wb #(.AW(AW), .DW(DW), .DEBUG(0)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_bte_i  (wb_bte_i),
        .wb_cti_i  (wb_cti_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_rty_o  (wb_rty_o),
        .cmd_valid (cmd_valid),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .cmd_burst (cmd_burst),
        .cmd_last  (cmd_last),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_dat   (rsp_dat)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic [31:0] adr,
                                 input logic we, input logic [31:0] dat, input logic [3:0] sel,
                                 input logic [2:0] cti, input logic [1:0] bte);
        wb_cyc_i = cyc;
        wb_stb_i = stb;
        wb_adr_i = adr;
        wb_we_i  = we;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_cti_i = cti;
        wb_bte_i = bte;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ack"},   32'(wb_ack_o),  32'd0);
        checkOutput({tag, ".err"},   32'(wb_err_o),  32'd0);
        checkOutput({tag, ".rty"},   32'(wb_rty_o),  32'd0);
        checkOutput({tag, ".dat_o"}, wb_dat_o,       32'd0);
        checkOutput({tag, ".valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({tag, ".we"},    32'(cmd_we),    32'd0);
        checkOutput({tag, ".adr"},   cmd_adr,        32'd0);
        checkOutput({tag, ".cdat"},  cmd_dat,        32'd0);
        checkOutput({tag, ".sel"},   32'(cmd_sel),   32'd0);
        checkOutput({tag, ".burst"}, 32'(cmd_burst), 32'd0);
        checkOutput({tag, ".last"},  32'(cmd_last),  32'd0);
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] adr);
        logic [31:0] key;
        key = {adr[31:2], 2'b00};
        if (mem.exists(key)) return mem[key];
        return key ^ 32'hA5A5_5A5A;
    endfunction

    function automatic void modelWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] w;
        w = modelRead(adr);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
        end
        mem[{adr[31:2], 2'b00}] = w;
    endfunction

    // Beat i of a burst: wrapping bursts stay inside an aligned block of 4/8/16 words.
    function automatic logic [31:0] modelAdr(input logic [31:0] start, input logic [1:0] bte,
                                             input bit constAdr, input int i);
        logic [31:0] blk;
        logic [31:0] base;
        if (constAdr) return start;
        if (bte == 2'b00) return start + 32'(4 * i);
        case (bte)
            2'b01:   blk = 32'd16;
            2'b10:   blk = 32'd32;
            default: blk = 32'd64;
        endcase
        base = start - (start % blk);
        return base + ((start - base + 32'(4 * i)) % blk);
    endfunction

    task automatic runBurst(input logic [31:0] startAdr, input logic [1:0] bte, input int beats,
                            input bit constAdr, input bit we, input int delay, input int errMask,
                            input logic [31:0] firstDat, input logic [3:0] firstSel, input bit gaps);
        logic [31:0] adr;
        logic [31:0] busAdr;
        logic [31:0] dat;
        logic [31:0] expRd;
        logic [3:0]  sel;
        logic [2:0]  cti;
        int          d;
        bit          isErr;
        for (int i = 0; i < beats; i++) begin
            adr    = modelAdr(startAdr, bte, constAdr, i);
            cti    = (beats == 1) ? 3'b000 : ((i == beats - 1) ? 3'b111 : (constAdr ? 3'b001 : 3'b010));
            dat    = (i == 0) ? firstDat : $urandom;
            sel    = (i == 0) ? firstSel : 4'($urandom_range(1, 15));
            busAdr = (i == 0) ? adr : $urandom;
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    applyStimulus(1'b1, 1'b0, busAdr, we, dat, sel, cti, bte);
                    step();
                    checkOutput("gap.valid", 32'(cmd_valid), 32'd0);
                    checkOutput("gap.ack", 32'(wb_ack_o), 32'd0);
                end
            end
            applyStimulus(1'b1, 1'b1, busAdr, we, dat, sel, cti, bte);
            step();
            checkOutput("req.valid", 32'(cmd_valid), 32'd1);
            checkOutput("req.adr", cmd_adr, adr);
            checkOutput("req.we", 32'(cmd_we), 32'(we));
            checkOutput("req.sel", 32'(cmd_sel), 32'(sel));
            if (we) checkOutput("req.cdat", cmd_dat, dat);
            checkOutput("req.last", 32'(cmd_last), 32'(i == beats - 1));
            checkOutput("req.burst", 32'(cmd_burst), 32'(beats > 1));
            checkOutput("req.ack", 32'(wb_ack_o), 32'd0);
            d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
            repeat (d) begin
                step();
                checkOutput("wait.ack", 32'(wb_ack_o), 32'd0);
                checkOutput("wait.err", 32'(wb_err_o), 32'd0);
                checkOutput("wait.valid", 32'(cmd_valid), 32'd1);
                checkOutput("wait.dat_o", wb_dat_o, 32'd0);
            end
            isErr     = errMask[i];
            expRd     = modelRead(adr);
            rsp_valid = 1'b1;
            rsp_err   = isErr;
            rsp_dat   = (we || isErr) ? $urandom : expRd;
            step();
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            rsp_dat   = $urandom;
            checkOutput("rsp.ack", 32'(wb_ack_o), 32'(!isErr));
            checkOutput("rsp.err", 32'(wb_err_o), 32'(isErr));
            checkOutput("rsp.dat_o", wb_dat_o, (we || isErr) ? 32'd0 : expRd);
            checkOutput("rsp.valid", 32'(cmd_valid), 32'd0);
            if (we && !isErr) modelWrite(adr, dat, sel);
            step();
            checkOutput("post.ack", 32'(wb_ack_o), 32'd0);
            checkOutput("post.err", 32'(wb_err_o), 32'd0);
            checkOutput("post.dat_o", wb_dat_o, 32'd0);
            if (i == beats - 1) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0, 2'd0);
        end
        step();
        checkOutput("idle.valid", 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        int beats;
        logic [1:0] bte;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0, 2'd0);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_dat   = 32'd0;
        wb_rst    = 1'b1;
        step();
        step();
        checkAllZero("reset");
        wb_rst = 1'b0;
        step();

        runBurst(32'h10, 2'b00, 1, 1'b0, 1'b1, 0, 0, 32'hDEAD_BEEF, 4'hF, 1'b0);
        checkOutput("mem.0x10", modelRead(32'h10), 32'hDEAD_BEEF);
        mem[32'h20] = 32'h1234_5678;
        runBurst(32'h20, 2'b00, 1, 1'b0, 1'b0, 3, 0, 32'd0, 4'hF, 1'b0);

        runBurst(32'h100, 2'b00, 4, 1'b0, 1'b1, -1, 0, $urandom, 4'hF, 1'b0);
        runBurst(32'h100, 2'b00, 4, 1'b0, 1'b0, -1, 0, 32'd0, 4'hF, 1'b1);
        runBurst(32'h0C, 2'b01, 4, 1'b0, 1'b1, -1, 0, $urandom, 4'hF, 1'b0);
        runBurst(32'h18, 2'b10, 8, 1'b0, 1'b0, -1, 0, 32'd0, 4'hF, 1'b1);
        runBurst(32'h9000, 2'b00, 1, 1'b0, 1'b0, 0, 1, 32'd0, 4'hF, 1'b0);
        runBurst(32'h400, 2'b00, 4, 1'b0, 1'b0, -1, 2, 32'd0, 4'hF, 1'b0);
        runBurst(32'h500, 2'b00, 3, 1'b1, 1'b1, -1, 0, $urandom, 4'h3, 1'b1);

        for (int t = 0; t < 24; t++) begin
            beats = int'($urandom_range(1, 8));
            bte   = 2'($urandom_range(0, 3));
            runBurst($urandom & 32'h0000_FFFC, bte, beats, (beats > 1) && ($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), -1,
                     ($urandom_range(0, 7) == 0) ? (1 << $urandom_range(0, beats - 1)) : 0,
                     $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end

        // Abort: cyc drops while the backend is still working on beat one.
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 32'd0, 4'hF, 3'b010, 2'b00);
        step();
        checkOutput("abort.valid0", 32'(cmd_valid), 32'd1);
        step();
        checkOutput("abort.valid1", 32'(cmd_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h200, 1'b0, 32'd0, 4'hF, 3'b010, 2'b00);
        #1;
        checkOutput("abort.drop", 32'(cmd_valid), 32'd0);
        rsp_valid = 1'b1;
        rsp_dat   = 32'hCAFE_F00D;
        step();
        rsp_valid = 1'b0;
        checkOutput("abort.ack", 32'(wb_ack_o), 32'd0);
        checkOutput("abort.err", 32'(wb_err_o), 32'd0);
        checkOutput("abort.dat_o", wb_dat_o, 32'd0);
        step();
        checkOutput("abort.ack2", 32'(wb_ack_o), 32'd0);
        runBurst(32'h600, 2'b00, 1, 1'b0, 1'b0, 1, 0, 32'd0, 4'hF, 1'b0);

        // Reset in the middle of a write burst with a response arriving at the same edge.
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 32'h1111_2222, 4'hF, 3'b010, 2'b00);
        step();
        checkOutput("rst.valid", 32'(cmd_valid), 32'd1);
        checkOutput("rst.adr", cmd_adr, 32'h300);
        wb_rst    = 1'b1;
        rsp_valid = 1'b1;
        step();
        checkAllZero("midrst");
        wb_rst    = 1'b0;
        rsp_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 3'd0, 2'd0);
        step();
        checkOutput("rst.idle", 32'(cmd_valid), 32'd0);
        runBurst(32'h700, 2'b01, 4, 1'b0, 1'b1, -1, 0, $urandom, 4'hF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
